// File: rtl/issue_scoreboard.sv
// In-order issue scoreboard: per-register pending-writer counters gate issue
// on RAW hazards and writer-count overflow, with a drain handshake for resteer.
module issue_scoreboard #(
  parameter int unsigned NREG    = 32,
  parameter int unsigned ID_W    = 5,
  parameter int unsigned ISSUE_W = 2,
  parameter int unsigned WB_W    = 2,
  parameter int unsigned CNT_W   = 2
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [ISSUE_W-1:0]             iss_valid,
  input  logic [ISSUE_W*ID_W-1:0]        iss_src0_id,
  input  logic [ISSUE_W*ID_W-1:0]        iss_src1_id,
  input  logic [ISSUE_W*ID_W-1:0]        iss_dst_id,
  output logic [ISSUE_W-1:0]             iss_grant,
  output logic [$clog2(ISSUE_W+1)-1:0]   iss_grant_cnt,
  input  logic [WB_W-1:0]                wb_valid,
  input  logic [WB_W*ID_W-1:0]           wb_dst_id,
  input  logic                           drain_req,
  output logic                           drain_done,
  output logic [NREG-1:0]                pending,
  output logic                           wb_err
);

  localparam int unsigned GCNT_W  = $clog2(ISSUE_W + 1);
  localparam int unsigned SUM_W   = CNT_W + $clog2(ISSUE_W + WB_W + 1) + 1;
  localparam int unsigned CNT_MAX = (2 ** CNT_W) - 1;

  typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_DONE} state_e;

  state_e                 r_state;
  state_e                 w_state_nxt;
  logic [CNT_W-1:0]       r_cnt     [NREG];
  logic [CNT_W-1:0]       w_cnt_nxt [NREG];
  logic [NREG-1:0]        r_pending;
  logic                   r_wb_err;
  logic                   r_drain_done;
  logic                   w_err_set;
  logic [ISSUE_W-1:0]     w_grant;
  logic [GCNT_W-1:0]      w_grant_cnt;

  // Id 0 and ids beyond the register file have no counter.
  function automatic logic tracked(input logic [ID_W-1:0] id);
    return (id != '0) && ({1'b0, id} < (ID_W + 1)'(NREG));
  endfunction

  // Grant chain: a lane issues only if every older lane issued and it is hazard-free.
  always_comb begin : grant_logic
    logic              ok;
    logic              stall;
    logic [ID_W-1:0]   s0, s1, d, dj;
    logic [SUM_W-1:0]  prior;
    w_grant     = '0;
    w_grant_cnt = '0;
    ok = (r_state == ST_RUN) && !drain_req && !reset;
    for (int i = 0; i < ISSUE_W; i++) begin
      s0    = iss_src0_id[i*ID_W +: ID_W];
      s1    = iss_src1_id[i*ID_W +: ID_W];
      d     = iss_dst_id[i*ID_W +: ID_W];
      stall = 1'b0;
      prior = '0;
      if (tracked(s0)) begin
        if (r_cnt[s0] != '0) stall = 1'b1;
      end
      if (tracked(s1)) begin
        if (r_cnt[s1] != '0) stall = 1'b1;
      end
      for (int j = 0; j < ISSUE_W; j++) begin
        dj = iss_dst_id[j*ID_W +: ID_W];
        if (j < i && w_grant[j]) begin
          if (s0 != '0 && s0 == dj) stall = 1'b1;
          if (s1 != '0 && s1 == dj) stall = 1'b1;
          if (dj == d) prior = prior + SUM_W'(1);
        end
      end
      if (tracked(d)) begin
        if (SUM_W'(r_cnt[d]) + prior + SUM_W'(1) > SUM_W'(CNT_MAX)) stall = 1'b1;
      end
      ok = ok && iss_valid[i] && !stall;
      w_grant[i] = ok;
      if (ok) w_grant_cnt = w_grant_cnt + GCNT_W'(1);
    end
  end

  // Net counter update; an underflowing write-back clamps to zero and flags an error.
  always_comb begin : cnt_logic
    logic [SUM_W-1:0] inc;
    logic [SUM_W-1:0] dec;
    logic [SUM_W-1:0] tot;
    w_err_set    = 1'b0;
    w_cnt_nxt[0] = '0;
    for (int r = 1; r < NREG; r++) begin
      inc = '0;
      dec = '0;
      for (int i = 0; i < ISSUE_W; i++) begin
        if (w_grant[i] && iss_dst_id[i*ID_W +: ID_W] == ID_W'(r)) inc = inc + SUM_W'(1);
      end
      for (int k = 0; k < WB_W; k++) begin
        if (wb_valid[k] && wb_dst_id[k*ID_W +: ID_W] == ID_W'(r)) dec = dec + SUM_W'(1);
      end
      tot = SUM_W'(r_cnt[r]) + inc;
      if (tot < dec) begin
        w_cnt_nxt[r] = '0;
        w_err_set    = 1'b1;
      end else begin
        w_cnt_nxt[r] = CNT_W'(tot - dec);
      end
    end
  end

  always_comb begin : fsm_next
    w_state_nxt = r_state;
    case (r_state)
      ST_RUN:   if (drain_req) w_state_nxt = ST_DRAIN;
      ST_DRAIN: if (r_pending == '0) w_state_nxt = ST_DONE;
      ST_DONE:  w_state_nxt = ST_RUN;
      default:  w_state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin : state_regs
    if (reset) begin
      r_state      <= ST_RUN;
      r_pending    <= '0;
      r_wb_err     <= 1'b0;
      r_drain_done <= 1'b0;
      for (int r = 0; r < NREG; r++) r_cnt[r] <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_wb_err     <= r_wb_err | w_err_set;
      r_drain_done <= (w_state_nxt == ST_DONE);
      for (int r = 0; r < NREG; r++) begin
        r_cnt[r]     <= w_cnt_nxt[r];
        r_pending[r] <= (w_cnt_nxt[r] != '0);
      end
    end
  end

  assign iss_grant     = w_grant;
  assign iss_grant_cnt = w_grant_cnt;
  assign pending       = r_pending;
  assign wb_err        = r_wb_err;
  assign drain_done    = r_drain_done;

endmodule

// File: tb/tb_issue_scoreboard.sv
// Directed bench for issue_scoreboard at default parameters (NREG=32, ID_W=5, 2 lanes, 2 wb ports, CNT_W=2).
module tb_issue_scoreboard;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  iss_valid;
  logic [9:0]  iss_src0_id, iss_src1_id, iss_dst_id;
  logic [1:0]  iss_grant;
  logic [1:0]  iss_grant_cnt;
  logic [1:0]  wb_valid;
  logic [9:0]  wb_dst_id;
  logic        drain_req;
  logic        drain_done;
  logic [31:0] pending;
  logic        wb_err;

  int total = 0;
  int bad   = 0;

  issue_scoreboard dut (
    .clk(clk), .reset(reset),
    .iss_valid(iss_valid), .iss_src0_id(iss_src0_id), .iss_src1_id(iss_src1_id),
    .iss_dst_id(iss_dst_id), .iss_grant(iss_grant), .iss_grant_cnt(iss_grant_cnt),
    .wb_valid(wb_valid), .wb_dst_id(wb_dst_id),
    .drain_req(drain_req), .drain_done(drain_done),
    .pending(pending), .wb_err(wb_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle();
    iss_valid   = '0;
    iss_src0_id = '0;
    iss_src1_id = '0;
    iss_dst_id  = '0;
    wb_valid    = '0;
    wb_dst_id   = '0;
    drain_req   = 1'b0;
  endtask

  task automatic lane(input int i, input logic [4:0] s0, input logic [4:0] s1, input logic [4:0] d);
    iss_valid[i]         = 1'b1;
    iss_src0_id[i*5 +: 5] = s0;
    iss_src1_id[i*5 +: 5] = s1;
    iss_dst_id[i*5 +: 5]  = d;
  endtask

  task automatic wb(input int k, input logic [4:0] d);
    wb_valid[k]         = 1'b1;
    wb_dst_id[k*5 +: 5] = d;
  endtask

  initial begin
    idle();
    reset = 1'b1;
    tick();
    // Reset suppresses grants even for a hazard-free candidate.
    lane(0, 5'd1, 5'd2, 5'd3);
    settle();
    chk("rst_grant", 32'(iss_grant), 32'd0);
    chk("rst_gcnt", 32'(iss_grant_cnt), 32'd0);
    tick();
    reset = 1'b0;
    idle();
    settle();
    chk("rst_pending", pending, 32'd0);
    chk("rst_wb_err", 32'(wb_err), 32'd0);
    chk("rst_done", 32'(drain_done), 32'd0);

    // Same-cycle RAW between lanes: lane1 reads lane0's destination.
    lane(0, 5'd0, 5'd0, 5'd5);
    lane(1, 5'd5, 5'd0, 5'd6);
    settle();
    chk("raw_lane_grant", 32'(iss_grant), 32'd1);
    chk("raw_lane_gcnt", 32'(iss_grant_cnt), 32'd1);
    tick();
    idle();
    chk("p5_set", 32'(pending[5]), 32'd1);
    chk("p6_clear", 32'(pending[6]), 32'd0);

    // No bypass: a write-back this cycle does not unblock a reader.
    lane(0, 5'd5, 5'd0, 5'd0);
    wb(0, 5'd5);
    settle();
    chk("nobypass_grant", 32'(iss_grant), 32'd0);
    tick();
    wb_valid = '0;
    settle();
    chk("p5_after_wb", 32'(pending[5]), 32'd0);
    chk("after_wb_grant", 32'(iss_grant), 32'd1);
    tick();
    idle();

    // WAW up to the counter limit: three writers of r7 granted, fourth stalls.
    for (int n = 0; n < 3; n++) begin
      lane(0, 5'd0, 5'd0, 5'd7);
      settle();
      chk($sformatf("waw_grant%0d", n), 32'(iss_grant), 32'd1);
      tick();
    end
    lane(1, 5'd0, 5'd0, 5'd7);
    wb(0, 5'd7);
    settle();
    chk("waw_full_grant", 32'(iss_grant), 32'd0);
    tick();
    wb_valid = '0;
    settle();
    // Counter at 2: lane0 takes it to 3, lane1 would overflow.
    chk("waw_one_free", 32'(iss_grant), 32'd1);
    tick();
    idle();
    chk("p7_full", 32'(pending[7]), 32'd1);
    wb(0, 5'd7);
    wb(1, 5'd7);
    tick();
    chk("p7_one_left", 32'(pending[7]), 32'd1);
    idle();
    wb(0, 5'd7);
    tick();
    idle();
    chk("p7_empty", 32'(pending[7]), 32'd0);

    // Simultaneous grant and write-back of r3 cancel out.
    lane(0, 5'd0, 5'd0, 5'd3);
    tick();
    idle();
    lane(0, 5'd0, 5'd0, 5'd3);
    wb(1, 5'd3);
    settle();
    chk("net_grant", 32'(iss_grant), 32'd1);
    tick();
    idle();
    chk("net_p3", 32'(pending[3]), 32'd1);
    chk("net_no_err", 32'(wb_err), 32'd0);
    wb(0, 5'd3);
    tick();
    idle();
    chk("net_p3_clear", 32'(pending[3]), 32'd0);

    // Drain with r10 and r11 outstanding.
    lane(0, 5'd0, 5'd0, 5'd10);
    lane(1, 5'd0, 5'd0, 5'd11);
    settle();
    chk("pre_drain_gcnt", 32'(iss_grant_cnt), 32'd2);
    tick();
    idle();
    drain_req = 1'b1;
    lane(0, 5'd0, 5'd0, 5'd12);
    settle();
    chk("drain_req_grant", 32'(iss_grant), 32'd0);
    tick();
    drain_req = 1'b0;
    settle();
    chk("drain_grant0", 32'(iss_grant), 32'd0);
    chk("drain_done0", 32'(drain_done), 32'd0);
    tick();
    wb(0, 5'd10);
    drain_req = 1'b1;
    settle();
    chk("drain_grant1", 32'(iss_grant), 32'd0);
    tick();
    wb_valid  = '0;
    drain_req = 1'b0;
    wb(1, 5'd11);
    settle();
    chk("drain_grant2", 32'(iss_grant), 32'd0);
    chk("drain_done2", 32'(drain_done), 32'd0);
    tick();
    wb_valid = '0;
    settle();
    chk("drain_zero_pend", pending, 32'd0);
    chk("drain_done3", 32'(drain_done), 32'd0);
    chk("drain_grant3", 32'(iss_grant), 32'd0);
    tick();
    chk("drain_done_pulse", 32'(drain_done), 32'd1);
    chk("drain_grant4", 32'(iss_grant), 32'd0);
    tick();
    chk("drain_done_end", 32'(drain_done), 32'd0);
    chk("resume_grant", 32'(iss_grant), 32'd1);
    tick();
    idle();
    wb(0, 5'd12);
    tick();
    idle();

    // Minimum drain latency with nothing pending: req, DRAIN, DONE.
    drain_req = 1'b1;
    tick();
    drain_req = 1'b0;
    chk("min_drain_c1", 32'(drain_done), 32'd0);
    tick();
    chk("min_drain_c2", 32'(drain_done), 32'd1);
    tick();
    chk("min_drain_c3", 32'(drain_done), 32'd0);

    // Underflowing write-back sets a sticky error; id 0 is ignored.
    wb(0, 5'd9);
    wb(1, 5'd0);
    tick();
    idle();
    chk("err_set", 32'(wb_err), 32'd1);
    chk("err_p9", 32'(pending[9]), 32'd0);
    lane(0, 5'd0, 5'd0, 5'd4);
    tick();
    idle();
    chk("err_sticky", 32'(wb_err), 32'd1);
    chk("p4_set", 32'(pending[4]), 32'd1);
    reset = 1'b1;
    wb(0, 5'd4);
    tick();
    reset = 1'b0;
    idle();
    chk("err_reset", 32'(wb_err), 32'd0);
    chk("pend_reset", pending, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
